// File: rtl/vram_arbiter.sv
// Two-requester VRAM port arbiter: round-robin ownership with a bounded burst,
// registered VRAM command outputs, and read data routed back to the issuer.
module vram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_rvalid,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_rvalid,

    output logic                  vram_we,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_wdata,
    output logic                  vram_re,
    input  logic [DATA_WIDTH-1:0] vram_rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic              last_q, last_d;

    logic                  vram_we_q, vram_re_q;
    logic [ADDR_WIDTH-1:0] vram_addr_q;
    logic [DATA_WIDTH-1:0] vram_wdata_q;

    logic                  rd_vld_p1_q;
    logic                  rd_id_p1_q;
    logic                  rvalid0_q, rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    logic                  acc0, acc1, acc_any;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // Ready comes from the grant state alone so it never loops back on valid.
    assign req0_ready = (state_q == GRANT0);
    assign req1_ready = (state_q == GRANT1);
    assign acc0       = req0_ready & req0_valid;
    assign acc1       = req1_ready & req1_valid;
    assign acc_any    = acc0 | acc1;
    assign cmd_we     = acc1 ? req1_we    : req0_we;
    assign cmd_addr   = acc1 ? req1_addr  : req0_addr;
    assign cmd_wdata  = acc1 ? req1_wdata : req0_wdata;

    // Grant state, burst counter and round-robin owner registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

    // Next grant: bounded burst while the other side waits, zero-gap handover.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                burst_d = '0;
                if (req0_valid && (!req1_valid || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0: begin
                if (req0_valid) begin
                    if (burst_q == CNT_LAST && req1_valid) begin
                        state_d = GRANT1;
                        burst_d = '0;
                        last_d  = 1'b1;
                    end else if (burst_q != CNT_LAST) begin
                        burst_d = burst_q + CNT_W'(1);
                    end
                end else if (req1_valid) begin
                    state_d = GRANT1;
                    burst_d = '0;
                    last_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    burst_d = '0;
                end
            end
            GRANT1: begin
                if (req1_valid) begin
                    if (burst_q == CNT_LAST && req0_valid) begin
                        state_d = GRANT0;
                        burst_d = '0;
                        last_d  = 1'b0;
                    end else if (burst_q != CNT_LAST) begin
                        burst_d = burst_q + CNT_W'(1);
                    end
                end else if (req0_valid) begin
                    state_d = GRANT0;
                    burst_d = '0;
                    last_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
    end

    // Register the accepted beat onto the VRAM port; strobes drop when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vram_we_q    <= 1'b0;
            vram_re_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
        end else begin
            vram_we_q <= acc_any & cmd_we;
            vram_re_q <= acc_any & ~cmd_we;
            if (acc_any) begin
                vram_addr_q  <= cmd_addr;
                vram_wdata_q <= cmd_wdata;
            end
        end
    end

    // Read tag pipeline: the tag rides with the strobe, then steers the
    // returning VRAM word to the issuing requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p1_q <= 1'b0;
            rd_id_p1_q  <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            rd_vld_p1_q <= acc_any & ~cmd_we;
            rd_id_p1_q  <= acc1;
            rvalid0_q   <= rd_vld_p1_q & ~rd_id_p1_q;
            rvalid1_q   <= rd_vld_p1_q & rd_id_p1_q;
            if (rd_vld_p1_q && !rd_id_p1_q) rdata0_q <= vram_rdata;
            if (rd_vld_p1_q && rd_id_p1_q)  rdata1_q <= vram_rdata;
        end
    end

    assign vram_we     = vram_we_q;
    assign vram_re     = vram_re_q;
    assign vram_addr   = vram_addr_q;
    assign vram_wdata  = vram_wdata_q;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

endmodule
